imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: UART bootloader that receives a framed program image and
// writes it word by word into instruction memory, holding the CPU in reset
// while a load is in progress or after a failed one.
//
// Frame: 0xA5 sync, word count N, 4*N data bytes (little-endian), XOR checksum.
//
// Load FSM states
//   state    | meaning
//   LD_IDLE  | waiting for sync byte; CPU released
//   LD_COUNT | sync seen, waiting for word count
//   LD_DATA  | assembling data bytes into words and writing them
//   LD_CHECK | all words written, waiting for checksum byte
//   LD_ERR   | load failed; CPU held until a new sync byte
//
// Receiver states
//   state    | meaning
//   RX_IDLE  | line idle, watching for a falling edge
//   RX_START | confirming the start bit at its centre
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit
module imem_loader #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int MAX_WORDS    = 64
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_M1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_N     = 8'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_IDLE, LD_COUNT, LD_DATA, LD_CHECK, LD_ERR} ld_state_t;

    // Synchronizer plus a delayed copy for edge detection. All three reset
    // low, so after reset the line must be seen high before a falling edge
    // can start a frame.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    ld_state_t   ld_state_q, ld_state_d;
    logic [7:0]  count_q, count_d;
    logic [6:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_sel_q, byte_sel_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic byte_ok, byte_bad, start_load, fail_load, last_word;

    // Two-flop synchronizer and edge-detect history for rx.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    // Receiver next state: down-counter reaches zero at each sample point.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_byte_d  = rx_byte_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_RELOAD;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_RELOAD;
                        rx_bit_d   = '0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_RELOAD;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_done_d  = 1'b1;
                    rx_ferr_d  = !rx_sync_q;
                    rx_byte_d  = rx_shift_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign byte_ok   = rx_done_q && !rx_ferr_q;
    assign byte_bad  = rx_done_q && rx_ferr_q;
    assign last_word = (({1'b0, word_idx_q} + 8'd1) == count_q);

    // Load FSM state and output registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ld_state_q <= LD_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_sel_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_sel_q <= byte_sel_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Load FSM next state; sync restart and failure are applied after the
    // case so IDLE/ERR and the three load states share one path each.
    always_comb begin
        ld_state_d = ld_state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_sel_d = byte_sel_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        start_load = 1'b0;
        fail_load  = 1'b0;
        case (ld_state_q)
            LD_IDLE, LD_ERR: begin
                if (byte_ok && rx_byte_q == SYNC_BYTE) begin
                    start_load = 1'b1;
                end
            end
            LD_COUNT: begin
                if (byte_bad) begin
                    fail_load = 1'b1;
                end else if (byte_ok) begin
                    count_d = rx_byte_q;
                    if (rx_byte_q == 8'd0 || rx_byte_q > MAX_N) begin
                        fail_load = 1'b1;
                    end else begin
                        ld_state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (byte_bad) begin
                    fail_load = 1'b1;
                end else if (byte_ok) begin
                    csum_d = csum_q ^ rx_byte_q;
                    if (byte_sel_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = {word_idx_q[5:0], 2'b00};
                        wdata_d    = {rx_byte_q, asm_q};
                        word_idx_d = word_idx_q + 7'd1;
                        byte_sel_d = 2'd0;
                        if (last_word) begin
                            ld_state_d = LD_CHECK;
                        end
                    end else begin
                        asm_d      = {rx_byte_q, asm_q[23:8]};
                        byte_sel_d = byte_sel_q + 2'd1;
                    end
                end
            end
            LD_CHECK: begin
                if (byte_bad) begin
                    fail_load = 1'b1;
                end else if (byte_ok) begin
                    if (rx_byte_q == csum_q) begin
                        ld_state_d = LD_IDLE;
                        done_d     = 1'b1;
                        hold_d     = 1'b0;
                    end else begin
                        fail_load = 1'b1;
                    end
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase

        if (start_load) begin
            ld_state_d = LD_COUNT;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            csum_d     = '0;
            word_idx_d = '0;
            byte_sel_d = '0;
        end
        if (fail_load) begin
            ld_state_d = LD_ERR;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b1;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
